seq_pattern_tx: RTL
===================

// Module: seq_pattern_tx
// PURPOSE
//   Serial pattern transmitter. Drives a 1-bit serial line with a latched PAT_W-bit pattern, MSB first, one bit per clk.
//   Repeats the pattern a programmable number of times, with optional idle gaps between repetitions.
//   Acts as the stimulus/source end of a serial link. Its output feeds the team's Moore sequence detectors (x input).
// PARAMETERS
//   PAT_W    4        pattern length in bits (>=2)
//   CNT_W    8        width of repeat count
//   GAP_W    4        width of inter-pattern gap count
// PORTS
//   clk       in   1      clock, rising edge
//   rst       in   1      reset, asynchronous, active-low
//   start     in   1      request transmission; sampled only in IDLE
//   abort     in   1      synchronous abort; returns to IDLE next edge
//   pattern   in   PAT_W  pattern to send; latched on accepted start
//   repeat_n  in   CNT_W  number of transmissions; 0 treated as 1
//   gap_n     in   GAP_W  idle cycles between repetitions; 0 = back-to-back
//   x_out     out  1      serial data bit (0 when not valid)
//   valid     out  1      x_out carries a pattern (or parity) bit this cycle
//   busy      out  1      high from cycle after accepted start until done cycle inclusive
//   done      out  1      one-cycle pulse, coincident with final bit of final repetition
// BEHAVIOUR
//   - Reset: state IDLE; x_out=0, valid=0, busy=0, done=0; counters and pattern register cleared. All outputs registered (Moore).
//   - FSM states: IDLE, SHIFT, GAP, PAR (PAR exists only with SEQ_TX_PARITY_EN).
//   - IDLE: start=1 & abort=0 at edge k latches pattern, repeat_n, gap_n -> SHIFT.
//     Bit pattern[PAT_W-1] appears on x_out during cycle k+1 with valid=1, busy=1.
//   - SHIFT: one bit per cycle, MSB->LSB. Bit index counts PAT_W-1..0.
//     After the LSB: if repetitions remain and gap_n>0 -> GAP. If repetitions remain and gap_n=0 -> next MSB immediately (no bubble).
//     Otherwise -> IDLE.
//   - GAP: x_out=0, valid=0, busy=1 for exactly gap_n cycles, then SHIFT from MSB.
//   - done=1 only in the cycle carrying the last transmitted bit (LSB, or parity bit if enabled) of the last repetition.
//     Next cycle busy=0, and start is accepted again from that cycle.
//   - Total active cycles = R*PAT_W + (R-1)*gap_n, with R=max(repeat_n,1).
//   - start while busy: ignored (no queuing). pattern/repeat_n/gap_n changes mid-transmission: ignored.
//   - abort (any state): next edge -> IDLE, outputs to reset values, done NOT pulsed. abort and start together in IDLE: abort wins.
//   - rst deassert/assert mid-transmission: immediate async return to reset values; no partial resume.
//   - Repeat counter counts down from R; no wrap. repeat_n=max (2^CNT_W-1) must complete exactly that many.
// CONFIGURATION
//   SEQ_TX_PARITY_EN defined: after each LSB, one PAR cycle drives the even-parity bit (^pattern) with valid=1.
//     Per-repetition length becomes PAT_W+1. done moves to the final parity bit.
//   SEQ_TX_PARITY_EN undefined: PAR state and logic absent; repetition length PAT_W.
// STRUCTURE
//   Package seq_pkg: state encoding (IDLE/SHIFT/GAP/PAR localparams) and PAT_DEFAULT=4'b1010.
//   Sub-module seq_tx_shreg: PAT_W-bit load/shift-left register with parallel load, MSB tap, and bit-index counter.
//   Top: FSM, repeat/gap counters, output registers.
// TESTING
//   1. pattern=1010, repeat_n=1, gap_n=0, start at edge k -> x_out 1,0,1,0 in cycles k+1..k+4, valid=1 throughout.
//      done=1 only at k+4; busy=0 at k+5.
//   2. pattern=1010, repeat_n=3, gap_n=0 -> 12 contiguous valid bits 101010101010, single done on 12th bit.
//   3. pattern=1001, repeat_n=2, gap_n=2 -> 1,0,0,1,(0,v=0),(0,v=0),1,0,0,1; busy continuous over all 10 cycles.
//   4. repeat_n=0 -> same as repeat_n=1. start pulsed during busy -> no extra transmission.
//   5. abort asserted on 3rd bit -> IDLE next cycle, valid=busy=0, no done pulse. Then start in the following cycle is accepted.
//      Repeat with rst low mid-frame -> outputs zero immediately.
//   6. SEQ_TX_PARITY_EN, pattern=1011, repeat_n=1 -> x_out 1,0,1,1,1 (parity=1); done on 5th bit.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared constants for the serial pattern transmitter.
//   ST_*        FSM state encodings (ST_PAR only reachable with SEQ_TX_PARITY_EN)
//   PAT_DEFAULT reference 4-bit pattern used by the link bring-up flows
package seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_PAR   = 2'd3;

    localparam logic [3:0] PAT_DEFAULT = 4'b1010;

endpackage

// File: rtl/seq_tx_shreg.sv
// seq_tx_shreg: pattern register with parallel load, one-bit shift and
// bit-index counter for the serial transmitter.
//   clk, rst   clock / async active-low reset
//   clr        synchronous clear (abort / end of frame)
//   load       load din, index := PAT_W-1 (MSB currently on the line)
//   shift      advance one bit, index decrements
//   din        pattern to load
//   nxt        bit that goes on the line after the next shift
//   idx        index of the bit currently on the line
module seq_tx_shreg #(
    parameter int PAT_W = 4,
    parameter int IDX_W = $clog2(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] din,
    output logic             nxt,
    output logic [IDX_W-1:0] idx
);

    logic [PAT_W-1:0] sh;

    // Rotate rather than shift: the register is reloaded before the
    // wrapped bit could ever reach the tap, and every bit stays live.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh  <= '0;
            idx <= '0;
        end else if (clr) begin
            sh  <= '0;
            idx <= '0;
        end else if (load) begin
            sh  <= din;
            idx <= IDX_W'(PAT_W - 1);
        end else if (shift) begin
            sh  <= {sh[PAT_W-2:0], sh[PAT_W-1]};
            idx <= idx - 1'b1;
        end
    end

    assign nxt = sh[PAT_W-2];

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter, MSB first, one bit per clk,
// repeated max(repeat_n,1) times with gap_n idle cycles between repetitions.
//   clk, rst   clock / async active-low reset
//   start      request transmission (sampled in IDLE only)
//   abort      synchronous abort, back to IDLE, no done pulse
//   pattern    PAT_W-bit pattern, latched on accepted start
//   repeat_n   repetition count (0 behaves as 1)
//   gap_n      idle cycles between repetitions
//   x_out      serial bit (0 when not valid)
//   valid      x_out carries a pattern/parity bit
//   busy       transmission in progress (through the done cycle)
//   done       pulse with the final bit of the final repetition
// Optional feature: define SEQ_TX_PARITY_EN to append an even-parity bit
// after every repetition.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap_n,
    output logic             x_out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(PAT_W);
`ifdef SEQ_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic [1:0]       state, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] rep_cnt, rep_d;
    logic [GAP_W-1:0] gap_q, gap_qd, gap_cnt, gapc_d;
    logic             x_d, valid_d, busy_d, done_d;
    logic             sh_clr, sh_load, sh_shift, sh_nxt, rep_end;
    logic [PAT_W-1:0] sh_din;
    logic [IDX_W-1:0] idx;
    logic             last_rep;

    seq_tx_shreg #(.PAT_W(PAT_W), .IDX_W(IDX_W)) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .clr   (sh_clr),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (sh_din),
        .nxt   (sh_nxt),
        .idx   (idx)
    );

    assign last_rep = (rep_cnt == CNT_W'(1));

    // Next-state/next-output logic; outputs are registered so each branch
    // describes what the line shows in the following cycle.
    always_comb begin
        state_d  = state;
        pat_d    = pat_q;
        rep_d    = rep_cnt;
        gap_qd   = gap_q;
        gapc_d   = gap_cnt;
        x_d      = 1'b0;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        sh_clr   = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_din   = pat_q;
        rep_end  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    rep_d   = (repeat_n == '0) ? CNT_W'(1) : repeat_n;
                    gap_qd  = gap_n;
                    sh_din  = pattern;
                    sh_load = 1'b1;
                    x_d     = pattern[PAT_W-1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (idx != '0) begin
                    sh_shift = 1'b1;
                    x_d      = sh_nxt;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    // Next cycle carries the LSB; it is the final bit only
                    // when no parity bit follows.
                    done_d   = (idx == IDX_W'(1)) && last_rep && !PAR_EN;
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    x_d     = ^pat_q;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = last_rep;
                    state_d = ST_PAR;
`else
                    rep_end = 1'b1;
`endif
                end
            end
            ST_GAP: begin
                busy_d = 1'b1;
                if (gap_cnt == GAP_W'(1)) begin
                    sh_load = 1'b1;
                    x_d     = pat_q[PAT_W-1];
                    valid_d = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    gapc_d = gap_cnt - 1'b1;
                end
            end
`ifdef SEQ_TX_PARITY_EN
            ST_PAR: rep_end = 1'b1;
`endif
            default: begin
                state_d = ST_IDLE;
                sh_clr  = 1'b1;
            end
        endcase

        // Last bit of a repetition has just been shown: either restart
        // (optionally via GAP) or finish.
        if (rep_end) begin
            if (!last_rep) begin
                rep_d  = rep_cnt - 1'b1;
                busy_d = 1'b1;
                if (gap_q != '0) begin
                    gapc_d  = gap_q;
                    state_d = ST_GAP;
                end else begin
                    sh_load = 1'b1;
                    x_d     = pat_q[PAT_W-1];
                    valid_d = 1'b1;
                    state_d = ST_SHIFT;
                end
            end else begin
                sh_clr  = 1'b1;
                state_d = ST_IDLE;
            end
        end

        // abort overrides everything, including a start in IDLE.
        if (abort) begin
            state_d  = ST_IDLE;
            x_d      = 1'b0;
            valid_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            sh_clr   = 1'b1;
            sh_load  = 1'b0;
            sh_shift = 1'b0;
            pat_d    = pat_q;
            rep_d    = rep_cnt;
            gap_qd   = gap_q;
            gapc_d   = gap_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            pat_q   <= '0;
            rep_cnt <= '0;
            gap_q   <= '0;
            gap_cnt <= '0;
            x_out   <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            pat_q   <= pat_d;
            rep_cnt <= rep_d;
            gap_q   <= gap_qd;
            gap_cnt <= gapc_d;
            x_out   <= x_d;
            valid   <= valid_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule
